// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter feeding one shared uart_tx
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DBIT    = 8,
    parameter int MAX_PKT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           last,
    input  logic [NREQ*DBIT-1:0]      data,
    output logic [NREQ-1:0]           ack,
    output logic                      tx_start,
    output logic [DBIT-1:0]           din,
    input  logic                      tx_done_tick,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_PKT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GW-1:0]   r_ptr;
    logic [GW-1:0]   r_grant;
    logic [CW-1:0]   r_cnt;
    logic [DBIT-1:0] r_din;
    logic            r_last_q;
    logic [GW-1:0]   w_sel;
    logic [GW-1:0]   w_idx;
    logic            w_found;
    logic            w_release;

    // Scan starting just past the last grant so that index gets lowest priority.
    always_comb begin
        w_sel   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = GW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_release = r_last_q || (r_cnt == CW'(MAX_PKT)) || !req[r_grant];

    always_comb begin
        w_state_nxt = r_state;
        tx_start    = 1'b0;
        ack         = '0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_found) w_state_nxt = S_START;
            end
            S_START: begin
                tx_start     = 1'b1;
                ack[r_grant] = 1'b1;
                w_state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done_tick) w_state_nxt = w_release ? S_IDLE : S_START;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= GW'(NREQ - 1);
            r_grant  <= '0;
            r_cnt    <= '0;
            r_din    <= '0;
            r_last_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_sel;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    r_din    <= data[int'(r_grant)*DBIT +: DBIT];
                    r_last_q <= last[r_grant];
                    r_cnt    <= r_cnt + CW'(1);
                end
                S_WAIT: begin
                    if (tx_done_tick && w_release) r_ptr <= r_grant;
                end
                default: ;
            endcase
        end
    end

    assign din      = r_din;
    assign grant_id = r_grant;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a 160-cycle transmitter model
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int DBIT = 8;
    localparam int MAXP = 16;
    localparam int TXC  = 160;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ-1:0]      last = '0;
    logic [NREQ*DBIT-1:0] data = '0;
    logic [NREQ-1:0]      ack;
    logic                 tx_start;
    logic [DBIT-1:0]      din;
    logic                 tx_done_tick = 1'b0;
    logic [1:0]           grant_id;
    logic                 busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .MAX_PKT(MAXP)) dut (
        .clk(clk), .reset(reset), .req(req), .last(last), .data(data), .ack(ack),
        .tx_start(tx_start), .din(din), .tx_done_tick(tx_done_tick),
        .grant_id(grant_id), .busy(busy)
    );

    typedef struct {logic [7:0] d; logic l; logic drop;} item_t;
    item_t      drv_q[NREQ][$];
    item_t      exp_q[NREQ][$];
    int         glog[$];
    logic [7:0] dlog[$];
    int         ack_cnt[NREQ];
    int         checks = 0;
    int         errors = 0;
    bit         eager = 1'b0, spur = 1'b0, gen = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [NREQ-1:0] r, input int p);
        for (int k = 1; k <= NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic present(input int i);
        req[i] = 1'b1;
        exp_q[i].push_back(drv_q[i][0]);
    endtask

    task automatic put(input int i, input logic [7:0] d, input logic l);
        item_t it;
        it.d = d; it.l = l; it.drop = 1'b0;
        drv_q[i].push_back(it);
    endtask

    function automatic bit pending();
        bit p;
        p = busy || (req != '0);
        for (int i = 0; i < NREQ; i++) if (drv_q[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: drain timeout after %0d cycles, required idle", nm, n);
        end
        repeat (4) @(posedge clk);
    endtask

    // Requester cores: hold req/data/last until ack, then present the next byte or drop.
    initial begin
        logic [NREQ-1:0] a;
        item_t           it;
        int              n;
        forever begin
            @(negedge clk);
            a = ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (gen && drv_q[i].size() == 0 && $urandom_range(199) == 0) begin
                    n = int'($urandom_range(20, 1));
                    for (int k = 0; k < n; k++) begin
                        it.d = 8'($urandom); it.l = (k == n - 1); it.drop = ($urandom_range(9) == 0);
                        drv_q[i].push_back(it);
                    end
                end
                if (a[i] && req[i]) begin
                    it = drv_q[i].pop_front();
                    req[i] = 1'b0;
                    if (drv_q[i].size() > 0 && !it.drop && (eager || $urandom_range(1) == 1)) present(i);
                end else if (!req[i] && drv_q[i].size() > 0 && (eager || $urandom_range(5) == 0)) begin
                    present(i);
                end
                if (req[i]) begin
                    data[i*DBIT +: DBIT] = drv_q[i][0].d;
                    last[i]              = drv_q[i][0].l;
                end
            end
        end
    end

    // Transmitter: done tick 160 cycles after tx_start; optional spurious ticks while idle.
    initial begin
        int   t;
        logic st, rs;
        t = 0;
        forever begin
            @(posedge clk);
            st = tx_start; rs = reset;
            #1;
            tx_done_tick = 1'b0;
            if (!rs) t = 0;
            else if (st) t = TXC - 1;
            else if (t > 0) begin
                t--;
                if (t == 0) tx_done_tick = 1'b1;
            end else if (spur && !busy && $urandom_range(15) == 0) tx_done_tick = 1'b1;
        end
    end

    // Reference model and scoreboard.
    initial begin
        int    holder, last_g, cnt, pend_g, nxt_g;
        bit    cur_idle, nxt_start, this_start, outstanding, pend, cur_last;
        item_t it;
        logic [NREQ-1:0] oh;
        holder = -1; last_g = NREQ - 1; cnt = 0; pend_g = 0; nxt_g = 0;
        cur_idle = 1'b1; nxt_start = 1'b0; outstanding = 1'b0; pend = 1'b0; cur_last = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                if (exp_q[pend_g].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL din_unexpected: got %0h from requester %0d, required no byte", din, pend_g);
                end else begin
                    it = exp_q[pend_g].pop_front();
                    chk("din", din, it.d);
                    cur_last = it.l;
                    dlog.push_back(din);
                end
            end
            this_start = nxt_start;
            chk("tx_start", tx_start, nxt_start);
            chk("busy", busy, !cur_idle);
            oh = '0;
            if (this_start) oh[nxt_g] = 1'b1;
            chk("ack", ack, oh);
            if (this_start) begin
                chk("grant_id", grant_id, nxt_g);
                cnt = (holder == nxt_g) ? cnt + 1 : 1;
                holder = nxt_g; outstanding = 1'b1; pend = 1'b1; pend_g = nxt_g;
                glog.push_back(nxt_g);
                ack_cnt[nxt_g]++;
            end
            if (!reset) begin
                holder = -1; last_g = NREQ - 1; cur_idle = 1'b1; nxt_start = 1'b0;
                outstanding = 1'b0; pend = 1'b0;
            end else if (cur_idle) begin
                if (req != '0) begin
                    nxt_g = rr(req, last_g); nxt_start = 1'b1; cur_idle = 1'b0;
                end
            end else if (this_start) begin
                nxt_start = 1'b0;
            end else if (tx_done_tick && outstanding) begin
                outstanding = 1'b0;
                if (cur_last || cnt == MAXP || !req[holder]) begin
                    last_g = holder; holder = -1; cur_idle = 1'b1;
                end else begin
                    nxt_start = 1'b1; nxt_g = holder;
                end
            end
        end
    end

    initial begin
        #1_500_000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int a2, n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_din", din, 0);
        chk("rst_grant_id", grant_id, 0);
        @(posedge clk); #2 reset = 1'b1;

        // Single 3-byte packet from requester 0.
        @(posedge clk); #2;
        eager = 1'b1; glog.delete(); dlog.delete();
        put(0, 8'h41, 1'b0); put(0, 8'h42, 1'b0); put(0, 8'h43, 1'b1);
        drain("pkt3", 2000);
        chk("pkt3_count", dlog.size(), 3);
        chk("pkt3_b0", dlog[0], 8'h41);
        chk("pkt3_b1", dlog[1], 8'h42);
        chk("pkt3_b2", dlog[2], 8'h43);

        // All four requesters with 1-byte packets: strict rotation.
        @(posedge clk); #2;
        glog.delete();
        for (int i = 0; i < NREQ; i++) begin put(i, 8'(16*i), 1'b1); put(i, 8'(16*i + 1), 1'b1); end
        drain("rotate", 3000);
        chk("rotate_count", glog.size(), 8);
        for (int k = 0; k < 8; k++) chk("rotate_order", glog[k], (1 + k) % NREQ);

        // Requester 2 streams 40 bytes, requester 1 waits: forced release after MAX_PKT.
        @(posedge clk); #2;
        glog.delete(); a2 = ack_cnt[2];
        for (int k = 0; k < 40; k++) put(2, 8'(k + 8'h80), k == 39);
        repeat (3) @(posedge clk); #2;
        put(1, 8'h5A, 1'b1);
        drain("maxpkt", 9000);
        chk("maxpkt_count", glog.size(), 41);
        chk("maxpkt_first16", glog[15], 2);
        chk("maxpkt_switch", glog[16], 1);
        chk("maxpkt_back", glog[17], 2);
        chk("maxpkt_acks", ack_cnt[2] - a2, 40);

        // Requester 3 drops req after its 2nd byte; then spurious ticks while idle.
        @(posedge clk); #2;
        glog.delete();
        put(3, 8'hC1, 1'b0); put(3, 8'hC2, 1'b0);
        drain("drop", 2000);
        chk("drop_grants", glog.size(), 2);
        spur = 1'b1;
        repeat (300) @(posedge clk);
        spur = 1'b0;
        chk("spurious_no_start", glog.size(), 2);
        @(posedge clk); #2;
        glog.delete();
        put(0, 8'h11, 1'b1); put(3, 8'h33, 1'b1);
        drain("ptr3", 2000);
        chk("ptr3_first", glog[0], 0);
        chk("ptr3_second", glog[1], 3);

        // Reset during WAIT of byte 2 of a 4-byte packet; requester re-presents byte 2.
        @(posedge clk); #2;
        glog.delete();
        put(0, 8'hA0, 1'b0); put(0, 8'hA1, 1'b0); put(0, 8'hA2, 1'b0); put(0, 8'hA3, 1'b1);
        n = 0;
        while (glog.size() < 2 && n < 2000) begin @(posedge clk); n++; end
        chk("rst_mid_reached", n < 2000, 1);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        begin
            item_t it;
            it.d = 8'hA1; it.l = 1'b0; it.drop = 1'b0;
            drv_q[0].push_front(it);
            exp_q[0].delete();
            exp_q[0].push_back(it);
        end
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ack", ack, 0);
        chk("rst_mid_tx_start", tx_start, 0);
        chk("rst_mid_din", din, 0);
        dlog.delete();
        drain("rst_mid", 3000);
        chk("rst_mid_count", dlog.size(), 3);
        chk("rst_mid_b0", dlog[0], 8'hA1);
        chk("rst_mid_b1", dlog[1], 8'hA2);
        chk("rst_mid_b2", dlog[2], 8'hA3);

        // Random traffic with spurious idle ticks.
        @(posedge clk); #2;
        eager = 1'b0; spur = 1'b1; gen = 1'b1;
        repeat (10000) @(posedge clk);
        #2 gen = 1'b0;
        drain("random", 40000);
        for (int i = 0; i < NREQ; i++) chk("random_all_sent", exp_q[i].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
